// File: rtl/pq_rr_arbiter.sv
// Round-robin arbiter that shares one hardware priority queue among NREQ clients.
// One PQ operation is in flight at a time; dequeued entries are routed back to the winner.

package pq_pkg;
    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;
    localparam logic [KEY_WIDTH-1:0] KEYINF = '1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    localparam kv_t KV_EMPTY = '{key: KEYINF, val: '0};
endpackage

module pq_rr_arbiter
    import pq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_enq,
    input  logic [NREQ-1:0] req_deq,
    input  kv_t             req_kv [NREQ],
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] rsp_valid,
    output kv_t             rsp_kv,
    output logic            pq_enq,
    output logic            pq_deq,
    output kv_t             pq_kvi,
    input  kv_t             pq_kvo,
    input  logic            pq_busy,
    input  logic            pq_full,
    input  logic            pq_empty
);

    localparam int KV_W = KEY_WIDTH + VAL_WIDTH;
    localparam int PW   = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n, cur, cur_n, win;
    logic            op_deq, op_deq_n, found, win_deq;
    logic [NREQ-1:0] deq_ok, elig;
    logic [NREQ-1:0] gnt_n, rsp_valid_n;
    logic            pq_enq_n, pq_deq_n;
    logic [KV_W-1:0] kvi_sel;
    kv_t             pq_kvi_n, rsp_kv_n;
    int              idx;

    // A deq takes precedence over an enq from the same requester when the PQ can serve it.
    assign deq_ok = req_deq & {NREQ{~pq_empty}};
    assign elig   = deq_ok | (req_enq & {NREQ{~pq_full}});

    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_deq = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && elig[PW'(idx)]) begin
                found   = 1'b1;
                win     = PW'(idx);
                win_deq = deq_ok[PW'(idx)];
            end
        end
    end

    assign kvi_sel = req_kv[win];

    // Next-state logic also computes the next value of every registered output.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        cur_n       = cur;
        op_deq_n    = op_deq;
        gnt_n       = '0;
        rsp_valid_n = '0;
        pq_enq_n    = 1'b0;
        pq_deq_n    = 1'b0;
        pq_kvi_n    = KV_EMPTY;
        rsp_kv_n    = rsp_kv;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n  = ISSUE;
                    cur_n    = win;
                    op_deq_n = win_deq;
                    gnt_n    = ONE << win;
                    pq_enq_n = ~win_deq;
                    pq_deq_n = win_deq;
                    pq_kvi_n = win_deq ? KV_EMPTY : kv_t'(kvi_sel);
                end
            end
            ISSUE: begin
                state_n = WAIT;
                ptr_n   = (cur == PW'(NREQ - 1)) ? '0 : cur + 1'b1;
            end
            WAIT: begin
                if (!pq_busy) begin
                    if (op_deq) begin
                        state_n     = RESP;
                        rsp_kv_n    = pq_kvo;
                        rsp_valid_n = ONE << cur;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            op_deq    <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            pq_enq    <= 1'b0;
            pq_deq    <= 1'b0;
            pq_kvi    <= KV_EMPTY;
            rsp_kv    <= KV_EMPTY;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cur       <= cur_n;
            op_deq    <= op_deq_n;
            gnt       <= gnt_n;
            rsp_valid <= rsp_valid_n;
            pq_enq    <= pq_enq_n;
            pq_deq    <= pq_deq_n;
            pq_kvi    <= pq_kvi_n;
            rsp_kv    <= rsp_kv_n;
        end
    end

endmodule

// File: tb/tb_pq_rr_arbiter.sv
// Directed bench for pq_rr_arbiter: the bench plays the requesters and a simple PQ.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_pq_rr_arbiter;
    import pq_pkg::*;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_enq = '0;
    logic [NREQ-1:0] req_deq = '0;
    kv_t             req_kv [NREQ];
    logic [NREQ-1:0] gnt, rsp_valid;
    kv_t             rsp_kv, pq_kvi;
    kv_t             pq_kvo = KV_EMPTY;
    logic            pq_enq, pq_deq;
    logic            pq_busy = 1'b0;
    logic            pq_full = 1'b0;
    logic            pq_empty = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pq_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_enq(req_enq), .req_deq(req_deq), .req_kv(req_kv),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_kv(rsp_kv),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
        .pq_kvo(pq_kvo), .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // lat = falling edges until a grant is seen, 0 if the budget runs out.
    task automatic wait_gnt(input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) req_kv[i] = KV_EMPTY;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (pq_enq !== 1'b0 || pq_deq !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes: got enq=%b deq=%b expected 0/0", pq_enq, pq_deq); end
        checks++; if (pq_kvi !== 16'hFF00) begin failures++; $display("[TB] FAIL reset_pq_kvi: got %h expected ff00", pq_kvi); end
        checks++; if (rsp_kv !== 16'hFF00) begin failures++; $display("[TB] FAIL reset_rsp_kv: got %h expected ff00", rsp_kv); end
        rst = 1'b0;
    endtask

    task automatic test_single_enq();
        int lat;
        req_kv[0]  = 16'h05A1;
        req_enq[0] = 1'b1;
        wait_gnt(6, lat);
        checks++; if (lat != 1) begin failures++; $display("[TB] FAIL single_enq_latency: got %0d expected 1", lat); end
        checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL single_enq_gnt: got %b expected 0001", gnt); end
        checks++; if (pq_enq !== 1'b1 || pq_deq !== 1'b0) begin failures++; $display("[TB] FAIL single_enq_strobe: got enq=%b deq=%b expected 1/0", pq_enq, pq_deq); end
        checks++; if (pq_kvi !== 16'h05A1) begin failures++; $display("[TB] FAIL single_enq_kvi: got %h expected 05a1", pq_kvi); end
        req_enq[0] = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000 || pq_enq !== 1'b0) begin failures++; $display("[TB] FAIL single_enq_pulse: got gnt=%b enq=%b expected 0000/0", gnt, pq_enq); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_all_enq();
        int lat;
        logic [15:0] kv;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            kv = 16'h1000 + 16'(i);
            req_kv[i] = kv;
        end
        for (int r = 0; r < 2; r++) begin
            req_enq = 4'hF;
            for (int i = 0; i < NREQ; i++) begin
                wait_gnt(8, lat);
                kv = 16'h1000 + 16'(i);
                checks++; if (gnt !== (4'b0001 << i)) begin failures++; $display("[TB] FAIL all_enq_order r%0d i%0d: got %b expected %b", r, i, gnt, 4'b0001 << i); end
                checks++; if (lat != ((r == 0 && i == 0) ? 1 : 3)) begin failures++; $display("[TB] FAIL all_enq_period r%0d i%0d: got %0d expected %0d", r, i, lat, (r == 0 && i == 0) ? 1 : 3); end
                checks++; if (pq_kvi !== kv) begin failures++; $display("[TB] FAIL all_enq_kvi r%0d i%0d: got %h expected %h", r, i, pq_kvi, kv); end
                req_enq[i] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_deq_on_empty();
        int lat;
        pq_empty   = 1'b1;
        req_kv[2]  = 16'h0377;
        req_deq[1] = 1'b1;
        req_enq[2] = 1'b1;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b0100 || pq_enq !== 1'b1) begin failures++; $display("[TB] FAIL empty_skip_gnt: got gnt=%b enq=%b expected 0100/1", gnt, pq_enq); end
        req_enq[2] = 1'b0;
        pq_empty   = 1'b0;
        pq_kvo     = 16'h0377;
        wait_gnt(8, lat);
        checks++; if (gnt !== 4'b0010 || pq_deq !== 1'b1) begin failures++; $display("[TB] FAIL empty_deq_gnt: got gnt=%b deq=%b expected 0010/1", gnt, pq_deq); end
        checks++; if (pq_kvi !== 16'hFF00) begin failures++; $display("[TB] FAIL empty_deq_kvi: got %h expected ff00", pq_kvi); end
        req_deq[1] = 1'b0;
        wait_rsp(6, lat);
        checks++; if (lat != 2) begin failures++; $display("[TB] FAIL empty_rsp_latency: got %0d expected 2", lat); end
        checks++; if (rsp_valid !== 4'b0010 || rsp_kv.key !== 8'h03) begin failures++; $display("[TB] FAIL empty_rsp: got valid=%b key=%h expected 0010/03", rsp_valid, rsp_kv.key); end
        pq_empty = 1'b1;
        pq_kvo   = KV_EMPTY;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_skip();
        int lat;
        logic seen;
        pq_full    = 1'b1;
        pq_empty   = 1'b0;
        pq_kvo     = 16'h0811;
        req_kv[3]  = 16'h4433;
        req_enq[3] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (gnt != '0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL full_no_gnt: got grant=%b expected 0", seen); end
        req_deq[0] = 1'b1;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b0001 || pq_deq !== 1'b1) begin failures++; $display("[TB] FAIL full_deq_gnt: got gnt=%b deq=%b expected 0001/1", gnt, pq_deq); end
        req_deq[0] = 1'b0;
        wait_rsp(6, lat);
        checks++; if (rsp_valid !== 4'b0001 || rsp_kv !== 16'h0811) begin failures++; $display("[TB] FAIL full_deq_rsp: got valid=%b kv=%h expected 0001/0811", rsp_valid, rsp_kv); end
        pq_full = 1'b0;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b1000 || pq_kvi !== 16'h4433) begin failures++; $display("[TB] FAIL full_drop_gnt: got gnt=%b kvi=%h expected 1000/4433", gnt, pq_kvi); end
        req_enq[3] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_busy_wait();
        int lat;
        logic act;
        pq_empty   = 1'b0;
        pq_kvo     = 16'h1234;
        req_deq[1] = 1'b1;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b0010 || pq_deq !== 1'b1) begin failures++; $display("[TB] FAIL busy_deq_gnt: got gnt=%b deq=%b expected 0010/1", gnt, pq_deq); end
        req_deq[1] = 1'b0;
        pq_busy    = 1'b1;
        act = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (gnt != '0 || rsp_valid != '0 || pq_enq || pq_deq) act = 1'b1;
        end
        checks++; if (act !== 1'b0) begin failures++; $display("[TB] FAIL busy_quiet: got activity=%b expected 0", act); end
        pq_busy = 1'b0;
        pq_kvo  = 16'h2345;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0010 || rsp_kv !== 16'h2345) begin failures++; $display("[TB] FAIL busy_rsp: got valid=%b kv=%h expected 0010/2345", rsp_valid, rsp_kv); end
        pq_kvo = 16'h7777;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000 || rsp_kv !== 16'h2345) begin failures++; $display("[TB] FAIL busy_rsp_hold: got valid=%b kv=%h expected 0000/2345", rsp_valid, rsp_kv); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int lat;
        pq_empty   = 1'b0;
        req_kv[0]  = 16'h0A0A;
        req_kv[3]  = 16'h3B3B;
        req_enq[3] = 1'b1;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("[TB] FAIL rstwait_first_gnt: got %b expected 1000", gnt); end
        pq_busy    = 1'b1;
        req_enq[0] = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (rsp_kv !== 16'hFF00 || pq_kvi !== 16'hFF00) begin failures++; $display("[TB] FAIL rstwait_async: got rsp_kv=%h kvi=%h expected ff00/ff00", rsp_kv, pq_kvi); end
        checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000 || pq_enq || pq_deq) begin failures++; $display("[TB] FAIL rstwait_outputs: got gnt=%b rsp=%b enq=%b deq=%b expected all 0", gnt, rsp_valid, pq_enq, pq_deq); end
        repeat (2) @(negedge clk);
        pq_busy = 1'b0;
        rst     = 1'b0;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b0001 || pq_kvi !== 16'h0A0A) begin failures++; $display("[TB] FAIL rstwait_regrant0: got gnt=%b kvi=%h expected 0001/0a0a", gnt, pq_kvi); end
        req_enq[0] = 1'b0;
        wait_gnt(6, lat);
        checks++; if (gnt !== 4'b1000 || lat != 3) begin failures++; $display("[TB] FAIL rstwait_regrant3: got gnt=%b lat=%0d expected 1000/3", gnt, lat); end
        req_enq[3] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting pq_rr_arbiter bench");
        test_reset();
        test_single_enq();
        test_all_enq();
        test_deq_on_empty();
        test_full_skip();
        test_busy_wait();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
